pc_branch_unit: RTL and testbench
=================================

// Module: pc_branch_unit
// PURPOSE
//  - Branch resolution and PC generation stage of the RV32I core.
//  - Consumes the EX-stage comparator outputs brEq/brLt, returns brUn, decides taken/not-taken per funct3.
//  - Computes the branch/jump target, owns the architectural PC register and drives the IF/ID and ID/EX flush.
//  - Holds a redirect raised under stall until the stall releases, so no redirect is lost.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  TRAP_VEC   32'h0000_0100  PC loaded on a misaligned-target exception
//  CNT_W      32             width of the taken-redirect statistics counter
// PORTS
//  clk          in   1      core clock, rising edge
//  rst          in   1      asynchronous reset, active-high
//  stall        in   1      pipeline hold from hazard unit; PC and internal state frozen
//  exValid      in   1      EX stage holds a valid instruction
//  exBranch     in   1      EX instruction is a conditional branch (B-type)
//  exJal        in   1      EX instruction is JAL
//  exJalr       in   1      EX instruction is JALR
//  exFunct3     in   3      funct3 of EX instruction
//  exPc         in   32     PC of EX instruction
//  exImm        in   32     sign-extended immediate of EX instruction
//  dataA        in   32     rs1 operand, also the JALR base
//  brEq         in   1      comparator: dataA == dataB
//  brLt         in   1      comparator: dataA < dataB, signed/unsigned per brUn
//  brUn         out  1      comparator mode; combinational, = exFunct3[1]
//  pc           out  32     current fetch PC (registered)
//  pcPlus4      out  32     pc + 4, mod 2^32
//  flush        out  1      kill IF/ID and ID/EX at this edge (combinational)
//  excMisalign  out  1      1-cycle pulse: taken target not word aligned
//  illBranch    out  1      1-cycle pulse: exBranch with funct3 = 010/011
//  takenCnt     out  CNT_W  count of applied redirects, wraps
// BEHAVIOUR
//  - Reset (async, rst=1): pc=RESET_PC, state=RUN, takenCnt=0, pending regs=0.
//    flush, excMisalign and illBranch read 0 while rst is high.
//  - Condition table (exBranch):
//    000 BEQ=brEq, 001 BNE=!brEq, 100 BLT=brLt, 101 BGE=!brLt, 110 BLTU=brLt, 111 BGEU=!brLt.
//    010/011: not taken; illBranch=1 for that cycle.
//  - take = exValid & (exJal | exJalr | (exBranch & cond)).
//  - Target: branch/JAL = exPc+exImm; JALR = (dataA+exImm) & ~32'h1. All sums mod 2^32, no overflow flag.
//  - misaligned = take & (target[1:0] != 0). Redirect then goes to TRAP_VEC and excMisalign pulses.
//  - FSM states RUN and PEND:
//    RUN, stall=0, take=1: flush=1; pc<=target (or TRAP_VEC); takenCnt++; stay RUN.
//    RUN, stall=0, take=0: pc<=pc+4; flush=0.
//    RUN, stall=1, take=1: latch target and misaligned; takenCnt++; excMisalign pulses now; pc holds; ->PEND; flush=0.
//    RUN, stall=1, take=0: pc holds.
//    PEND, stall=1: hold everything. EX inputs are ignored (same frozen instruction, no double count).
//    PEND, stall=0: flush=1; pc<=latched target; ->RUN. EX inputs ignored this cycle.
//  - Latency: decision and flush in the same cycle as the EX instruction. New PC visible 1 cycle later.
//  - Exception pulses fire once per instruction, never repeated while stalled.
//  - Priority: rst > stall > redirect > sequential pc+4.
//  - pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000. takenCnt wraps at 2^CNT_W.
//  - rst during PEND discards the pending redirect.
// STRUCTURE
//  - Shared core package: funct3 constants (F3_BEQ..F3_BGEU), RUN/PEND state encoding, RESET_PC/TRAP_VEC defaults.
//  - One sub-module: branch_cond (combinational funct3 x brEq/brLt -> cond, illegal).
//  - The Branch comparator itself is instantiated by the EX stage, not inside this block.
// TESTING
//  1 Reset then 3 idle cycles -> pc 0x0,0x4,0x8,0xC; flush=0; takenCnt=0.
//  2 BEQ (f3=000) brEq=1, exPc=0x20, exImm=0x10 -> flush=1 that cycle; next pc=0x30; takenCnt=1.
//  3 BLTU (f3=110) -> brUn=1. brLt=0 -> no flush, pc+4. BGE (f3=101) brLt=0 -> taken.
//  4 JALR dataA=0x1001, exImm=0x3 with stall=1 for 3 cycles:
//    pc held, flush=0, state PEND; stall drops -> flush=1, next pc=0x1004, takenCnt=1 (not 4).
//  5 JAL exPc=0x40, exImm=0x6 -> excMisalign one cycle, next pc=TRAP_VEC 0x100.
//  6 exBranch f3=010 -> illBranch=1, no flush. Separately, pc=0xFFFFFFFC no take -> pc=0x0.
//    Separately, rst mid-PEND -> pc=RESET_PC, no flush.

Source files
------------

// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the branch/PC stage: funct3 codes, FSM states, default vectors.
package pc_branch_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;
  localparam int unsigned CNT_W_DEF    = 32;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// EX-stage / hazard-unit bundle into the branch unit, and its PC/flush results.
interface pc_branch_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stall;
  logic             exValid;
  logic             exBranch;
  logic             exJal;
  logic             exJalr;
  logic [2:0]       exFunct3;
  logic [31:0]      exPc;
  logic [31:0]      exImm;
  logic [31:0]      dataA;
  logic             brEq;
  logic             brLt;
  logic             brUn;
  logic [31:0]      pc;
  logic [31:0]      pcPlus4;
  logic             flush;
  logic             excMisalign;
  logic             illBranch;
  logic [CNT_W-1:0] takenCnt;

  modport master (
    output stall, exValid, exBranch, exJal, exJalr, exFunct3, exPc, exImm, dataA, brEq, brLt,
    input  brUn, pc, pcPlus4, flush, excMisalign, illBranch, takenCnt
  );

  modport slave (
    input  stall, exValid, exBranch, exJal, exJalr, exFunct3, exPc, exImm, dataA, brEq, brLt,
    output brUn, pc, pcPlus4, flush, excMisalign, illBranch, takenCnt
  );
endinterface

// File: rtl/pc_branch_unit_branch_cond.sv
// Branch condition decode: funct3 plus comparator flags -> taken condition, illegal encoding.
module branch_cond
  import pc_branch_unit_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_brEq,
  input  logic       i_brLt,
  output logic       o_cond,
  output logic       o_illegal
);

  always_comb begin
    o_cond    = 1'b0;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_cond = i_brEq;
      F3_BNE:  o_cond = ~i_brEq;
      F3_BLT:  o_cond = i_brLt;
      F3_BGE:  o_cond = ~i_brLt;
      F3_BLTU: o_cond = i_brLt;
      F3_BGEU: o_cond = ~i_brLt;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Branch resolution and PC generation: owns the fetch PC, raises flush, and parks
// a redirect resolved under stall until the stall releases.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  pc_branch_unit_if.slave  bus
);

  state_t           r_state;
  state_t           w_stateNext;
  logic [31:0]      r_pc;
  logic [31:0]      r_pendPc;
  logic             r_pendMis;
  logic [CNT_W-1:0] r_takenCnt;

  logic             w_cond;
  logic             w_illegal;
  logic             w_take;
  logic [31:0]      w_target;
  logic             w_mis;
  logic [31:0]      w_dest;
  logic [31:0]      w_pcNext;
  logic             w_flush;
  logic             w_exc;
  logic             w_ill;
  logic             w_latch;
  logic             w_count;

  branch_cond u_branch_cond (
    .i_funct3  (bus.exFunct3),
    .i_brEq    (bus.brEq),
    .i_brLt    (bus.brLt),
    .o_cond    (w_cond),
    .o_illegal (w_illegal)
  );

  assign w_take   = bus.exValid & (bus.exJal | bus.exJalr | (bus.exBranch & w_cond));
  assign w_target = bus.exJalr ? ((bus.dataA + bus.exImm) & ~32'h1) : (bus.exPc + bus.exImm);
  assign w_mis    = w_take & is_misaligned(w_target);
  assign w_dest   = w_mis ? TRAP_VEC : w_target;

  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_flush     = 1'b0;
    w_exc       = 1'b0;
    w_ill       = 1'b0;
    w_latch     = 1'b0;
    w_count     = 1'b0;
    case (r_state)
      RUN: begin
        // Decision is counted and reported once, in the cycle it is first seen,
        // even if the redirect itself has to wait for the stall to drop.
        w_exc   = w_mis;
        w_count = w_take;
        if (bus.stall) begin
          if (w_take) begin
            w_latch     = 1'b1;
            w_stateNext = PEND;
          end
        end else begin
          // Illegal-encoding pulse waits for the instruction to leave EX so a
          // stalled, not-taken branch does not report repeatedly.
          w_ill = bus.exValid & bus.exBranch & w_illegal;
          if (w_take) begin
            w_flush  = 1'b1;
            w_pcNext = w_dest;
          end else begin
            w_pcNext = r_pc + 32'd4;
          end
        end
      end
      PEND: begin
        if (!bus.stall) begin
          w_flush     = 1'b1;
          w_pcNext    = r_pendMis ? TRAP_VEC : r_pendPc;
          w_stateNext = RUN;
        end
      end
      default: w_stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_pendPc   <= '0;
      r_pendMis  <= 1'b0;
      r_takenCnt <= '0;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
      if (w_latch) begin
        r_pendPc  <= w_target;
        r_pendMis <= w_mis;
      end
      if (w_count) begin
        r_takenCnt <= r_takenCnt + CNT_W'(1);
      end
    end
  end

  assign bus.brUn        = bus.exFunct3[1];
  assign bus.pc          = r_pc;
  assign bus.pcPlus4     = r_pc + 32'd4;
  assign bus.flush       = w_flush & ~rst;
  assign bus.excMisalign = w_exc & ~rst;
  assign bus.illBranch   = w_ill & ~rst;
  assign bus.takenCnt    = r_takenCnt;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed vector table, hand sequences, random run vs. reference model.
module tb_pc_branch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP   = 32'h0000_0100;
  localparam int unsigned CW     = 32;

  typedef struct {
    bit          valid;
    bit          br;
    bit          jal;
    bit          jalr;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
  } ins_t;

  typedef struct {
    string       name;
    ins_t        in;
    bit          flush;
    bit          mis;
    bit          ill;
    bit          brun;
    bit          seq;
    logic [31:0] nxt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_branch_unit_if #(.CNT_W(CW)) bus();

  pc_branch_unit #(
    .RESET_PC (RST_PC),
    .TRAP_VEC (TRAP),
    .CNT_W    (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_pend;
  logic [31:0] m_pendDest;
  // model predictions for the current cycle
  bit          e_flush, e_mis, e_ill, e_take;
  logic [31:0] e_dest;
  // DUT samples from the last cycle
  bit          s_flush, s_mis, s_ill, s_brun;

  ins_t IDLE;
  vec_t tbl [12];

  function automatic ins_t mk_ins(bit v, bit br, bit jal, bit jalr, logic [2:0] f3,
                                  logic [31:0] pc, logic [31:0] imm, logic [31:0] a, logic [31:0] b);
    ins_t x;
    x.valid = v; x.br = br; x.jal = jal; x.jalr = jalr; x.f3 = f3;
    x.pc = pc; x.imm = imm; x.a = a; x.b = b;
    return x;
  endfunction

  function automatic vec_t mk_vec(string n, ins_t x, bit fl, bit mi, bit il, bit bu, bit sq, logic [31:0] nx);
    vec_t v;
    v.name = n; v.in = x; v.flush = fl; v.mis = mi; v.ill = il; v.brun = bu; v.seq = sq; v.nxt = nx;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Comparator behaviour as the EX stage would produce it from real operands.
  task automatic apply(input ins_t x, input bit st);
    bit un;
    un           = (x.f3 == 3'b110) || (x.f3 == 3'b111);
    bus.stall    = st;
    bus.exValid  = x.valid;
    bus.exBranch = x.br;
    bus.exJal    = x.jal;
    bus.exJalr   = x.jalr;
    bus.exFunct3 = x.f3;
    bus.exPc     = x.pc;
    bus.exImm    = x.imm;
    bus.dataA    = x.a;
    bus.brEq     = (x.a == x.b);
    bus.brLt     = un ? (x.a < x.b) : ($signed(x.a) < $signed(x.b));
  endtask

  task automatic model_eval(input ins_t x, input bit st);
    bit          cond;
    logic [31:0] tgt;
    case (x.f3)
      3'b000:  cond = (x.a == x.b);
      3'b001:  cond = (x.a != x.b);
      3'b100:  cond = ($signed(x.a) <  $signed(x.b));
      3'b101:  cond = ($signed(x.a) >= $signed(x.b));
      3'b110:  cond = (x.a <  x.b);
      3'b111:  cond = (x.a >= x.b);
      default: cond = 1'b0;
    endcase
    e_take = x.valid && (x.jal || x.jalr || (x.br && cond));
    tgt    = x.jalr ? ((x.a + x.imm) & 32'hFFFF_FFFE) : (x.pc + x.imm);
    e_dest = (tgt % 4 != 0) ? TRAP : tgt;
    if (m_pend) begin
      e_take  = 1'b0;
      e_flush = !st;
      e_mis   = 1'b0;
      e_ill   = 1'b0;
    end else begin
      e_flush = e_take && !st;
      e_mis   = e_take && (tgt % 4 != 0);
      e_ill   = !st && x.valid && x.br && (x.f3 == 3'b010 || x.f3 == 3'b011);
    end
  endtask

  task automatic model_commit(input bit st);
    if (m_pend) begin
      if (!st) begin
        m_pc   = m_pendDest;
        m_pend = 1'b0;
      end
    end else if (e_take) begin
      m_cnt = m_cnt + 1;
      if (st) begin
        m_pend     = 1'b1;
        m_pendDest = e_dest;
      end else begin
        m_pc = e_dest;
      end
    end else if (!st) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic cycle(input ins_t x, input bit st);
    apply(x, st);
    model_eval(x, st);
    @(negedge clk);
    s_flush = bus.flush;
    s_mis   = bus.excMisalign;
    s_ill   = bus.illBranch;
    s_brun  = bus.brUn;
    chk("flush",       32'(bus.flush),       32'(e_flush));
    chk("excMisalign", 32'(bus.excMisalign), 32'(e_mis));
    chk("illBranch",   32'(bus.illBranch),   32'(e_ill));
    chk("brUn",        32'(bus.brUn),        32'(x.f3 == 3'b110 || x.f3 == 3'b111 || x.f3 == 3'b010 || x.f3 == 3'b011));
    chk("pc",          bus.pc,               m_pc);
    chk("pcPlus4",     bus.pcPlus4,          m_pc + 32'd4);
    chk("takenCnt",    bus.takenCnt,         m_cnt);
    @(posedge clk);
    model_commit(st);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(mk_ins(1, 0, 1, 0, 3'b000, 32'h40, 32'h6, 32'h0, 32'h0), 1'b0);
    #2;
    chk("rst_pc",    bus.pc,                   RST_PC);
    chk("rst_flush", 32'(bus.flush),           32'd0);
    chk("rst_exc",   32'(bus.excMisalign),     32'd0);
    chk("rst_cnt",   bus.takenCnt,             32'd0);
    apply(mk_ins(1, 1, 0, 0, 3'b010, 32'h40, 32'h8, 32'h1, 32'h2), 1'b0);
    #1;
    chk("rst_ill",   32'(bus.illBranch),       32'd0);
    m_pc       = RST_PC;
    m_cnt      = '0;
    m_pend     = 1'b0;
    m_pendDest = '0;
    apply(IDLE, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pcb;
    logic [31:0] cnt0;
    int unsigned taken_in_tbl;
    ins_t x;

    IDLE = mk_ins(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    //                 name       valid br jal jalr f3      exPc          exImm         dataA         dataB          fl mi il bu sq next
    tbl[0]  = mk_vec("beq_t",   mk_ins(1, 1, 0, 0, 3'b000, 32'h20,       32'h10,       32'h5,        32'h5),        1, 0, 0, 0, 0, 32'h30);
    tbl[1]  = mk_vec("bltu_n",  mk_ins(1, 1, 0, 0, 3'b110, 32'h60,       32'h20,       32'h9,        32'h3),        0, 0, 0, 1, 1, 32'h0);
    tbl[2]  = mk_vec("bge_t",   mk_ins(1, 1, 0, 0, 3'b101, 32'h100,      32'h40,       32'h9,        32'h3),        1, 0, 0, 0, 0, 32'h140);
    tbl[3]  = mk_vec("blt_neg", mk_ins(1, 1, 0, 0, 3'b100, 32'h200,      32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h1),      1, 0, 0, 0, 0, 32'h1F8);
    tbl[4]  = mk_vec("bltu_ng", mk_ins(1, 1, 0, 0, 3'b110, 32'h200,      32'h8,        32'hFFFF_FFFF, 32'h1),       0, 0, 0, 1, 1, 32'h0);
    tbl[5]  = mk_vec("bne_n",   mk_ins(1, 1, 0, 0, 3'b001, 32'h300,      32'h8,        32'h7,        32'h7),        0, 0, 0, 0, 1, 32'h0);
    tbl[6]  = mk_vec("jal_mis", mk_ins(1, 0, 1, 0, 3'b000, 32'h40,       32'h6,        32'h0,        32'h0),        1, 1, 0, 0, 0, 32'h100);
    tbl[7]  = mk_vec("jalr",    mk_ins(1, 0, 0, 1, 3'b000, 32'h80,       32'h3,        32'h1001,     32'h0),        1, 0, 0, 0, 0, 32'h1004);
    tbl[8]  = mk_vec("ill_010", mk_ins(1, 1, 0, 0, 3'b010, 32'h500,      32'h8,        32'h1,        32'h1),        0, 0, 1, 1, 1, 32'h0);
    tbl[9]  = mk_vec("inval",   mk_ins(0, 0, 1, 0, 3'b000, 32'h600,      32'h8,        32'h0,        32'h0),        0, 0, 0, 0, 1, 32'h0);
    tbl[10] = mk_vec("jalr_mis",mk_ins(1, 0, 0, 1, 3'b000, 32'h700,      32'h2,        32'h2000,     32'h0),        1, 1, 0, 0, 0, 32'h100);
    tbl[11] = mk_vec("bgeu_n",  mk_ins(1, 1, 0, 0, 3'b111, 32'h800,      32'h8,        32'h1,        32'hFFFF_FFFF), 0, 0, 0, 1, 1, 32'h0);

    do_reset();

    // reset followed by idle cycles
    for (int i = 0; i < 4; i++) begin
      chk("idle_pc", bus.pc, 32'(4 * i));
      cycle(IDLE, 1'b0);
    end
    chk("idle_cnt", bus.takenCnt, 32'd0);

    cnt0 = m_cnt;
    taken_in_tbl = 0;
    for (int i = 0; i < 12; i++) begin
      pcb = m_pc;
      cycle(tbl[i].in, 1'b0);
      chk({tbl[i].name, "_flush"}, 32'(s_flush), 32'(tbl[i].flush));
      chk({tbl[i].name, "_mis"},   32'(s_mis),   32'(tbl[i].mis));
      chk({tbl[i].name, "_ill"},   32'(s_ill),   32'(tbl[i].ill));
      chk({tbl[i].name, "_brun"},  32'(s_brun),  32'(tbl[i].brun));
      chk({tbl[i].name, "_next"},  bus.pc,       tbl[i].seq ? pcb + 32'd4 : tbl[i].nxt);
      if (tbl[i].flush) taken_in_tbl++;
    end
    chk("tbl_cnt", bus.takenCnt, cnt0 + taken_in_tbl);

    // JALR resolved under a 3-cycle stall
    do_reset();
    x = mk_ins(1, 0, 0, 1, 3'b000, 32'h0, 32'h3, 32'h1001, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(x, 1'b1);
      chk("stall_flush", 32'(s_flush), 32'd0);
      chk("stall_pc", bus.pc, 32'h0);
    end
    cycle(x, 1'b0);
    chk("rel_flush", 32'(s_flush), 32'd1);
    chk("rel_pc", bus.pc, 32'h1004);
    chk("rel_cnt", bus.takenCnt, 32'd1);

    // misaligned JAL under stall: one pulse, then trap on release
    x = mk_ins(1, 0, 1, 0, 3'b000, 32'h40, 32'h6, 32'h0, 32'h0);
    cycle(x, 1'b1);
    chk("mis_st1", 32'(s_mis), 32'd1);
    cycle(x, 1'b1);
    chk("mis_st2", 32'(s_mis), 32'd0);
    cycle(x, 1'b0);
    chk("mis_rel_exc", 32'(s_mis), 32'd0);
    chk("mis_rel_flush", 32'(s_flush), 32'd1);
    chk("mis_rel_pc", bus.pc, TRAP);
    chk("mis_rel_cnt", bus.takenCnt, 32'd2);

    // pc+4 wrap at the top of the address space
    cycle(mk_ins(1, 0, 1, 0, 3'b000, 32'hFFFF_FFF0, 32'hC, 32'h0, 32'h0), 1'b0);
    chk("wrap_pc", bus.pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", bus.pcPlus4, 32'h0);
    cycle(IDLE, 1'b0);
    chk("wrap_next", bus.pc, 32'h0);

    // reset while a redirect is pending discards it
    cycle(mk_ins(1, 0, 1, 0, 3'b000, 32'h80, 32'h10, 32'h0, 32'h0), 1'b1);
    do_reset();
    cycle(IDLE, 1'b0);
    chk("rstpend_flush", 32'(s_flush), 32'd0);
    chk("rstpend_pc", bus.pc, RST_PC + 32'd4);

    // randomized run against the model
    for (int i = 0; i < 600; i++) begin
      int unsigned k;
      k = $urandom_range(0, 9);
      x = IDLE;
      x.valid = ($urandom_range(0, 99) < 85);
      x.f3    = 3'($urandom);
      x.pc    = $urandom & 32'hFFFF_FFFC;
      x.a     = $urandom;
      x.b     = ($urandom_range(0, 3) == 0) ? x.a : $urandom;
      x.imm   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      if (k < 6)      x.br   = 1'b1;
      else if (k < 8) x.jal  = 1'b1;
      else if (k < 9) x.jalr = 1'b1;
      cycle(x, $urandom_range(0, 99) < 30);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
